// File: rtl/ucca_handler_pkg.sv
// Shared types and constants for the UCCA violation handler.
package ucca_handler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RST_HOLD  = 2'd1,
        WAIT_BOOT = 2'd2
    } state_t;

    localparam int          COUNT_W               = 8;
    localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

    function automatic int log_entry_w(input int num_src);
        return 32 + num_src;
    endfunction

endpackage

// File: rtl/ucca_viol_log.sv
// Overwrite-on-full FIFO of violation captures; the oldest entry is dropped when full.
module ucca_viol_log
    import ucca_handler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      fill;
    logic             full;
    logic             do_pop;

    always_comb begin
        full   = (fill == (PW+1)'(DEPTH));
        do_pop = pop && (fill != '0);
        empty  = (fill == '0);
        head   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A push into a full FIFO discards the head, exactly like a pop.
            if (do_pop || (push && full)) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop && !full) begin
                fill <= fill + 1'b1;
            end else if (do_pop && !push) begin
                fill <= fill - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ucca_violation_handler.sv
// Converts UCCA monitor violations into a timed CPU reset with forensic capture and boot supervision.
// Optional violation log FIFO enabled by defining UCCA_VIOL_LOG_EN.
module ucca_violation_handler
    import ucca_handler_pkg::*;
#(
    parameter int          NUM_SRC       = 4,
    parameter int          RESET_CYCLES  = 16,
    parameter int          BOOT_TIMEOUT  = 64,
    parameter logic [15:0] RESET_HANDLER = DEFAULT_RESET_HANDLER,
    parameter int          LOG_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] viol_in,
    input  logic [15:0]        pc,
    input  logic [15:0]        data_addr,
    output logic               sys_reset,
    output logic               viol_valid,
    output logic [NUM_SRC-1:0] viol_cause,
    output logic [15:0]        viol_pc,
    output logic [15:0]        viol_addr,
    output logic [7:0]         viol_count,
    output logic               boot_fail
`ifdef UCCA_VIOL_LOG_EN
    ,
    input  logic                               log_rd,
    output logic                               log_empty,
    output logic [log_entry_w(NUM_SRC)-1:0]    log_data
`endif
);

    if (NUM_SRC < 1) begin : g_chk_src
        $error("NUM_SRC must be at least 1");
    end
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_chk_rst
        $error("RESET_CYCLES must be in 1..255");
    end
    if (BOOT_TIMEOUT < 1 || BOOT_TIMEOUT > 255) begin : g_chk_boot
        $error("BOOT_TIMEOUT must be in 1..255");
    end
    if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_chk_log
        $error("LOG_DEPTH must be a power of two, at least 2");
    end

    localparam logic [COUNT_W-1:0] HOLD_LOAD = COUNT_W'(RESET_CYCLES - 1);
    localparam logic [COUNT_W-1:0] BOOT_LOAD = COUNT_W'(BOOT_TIMEOUT - 1);

    state_t             state;
    logic [COUNT_W-1:0] cnt;
    logic               capture;

    always_comb begin
        capture = (|viol_in) && (state == IDLE || state == WAIT_BOOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sys_reset  <= 1'b0;
            viol_valid <= 1'b0;
            viol_cause <= '0;
            viol_pc    <= '0;
            viol_addr  <= '0;
            viol_count <= '0;
            boot_fail  <= 1'b0;
        end else begin
            if (capture) begin
                viol_cause <= viol_in;
                viol_pc    <= pc;
                viol_addr  <= data_addr;
                viol_valid <= 1'b1;
                if (viol_count != '1) begin
                    viol_count <= viol_count + 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (capture) begin
                        state     <= RST_HOLD;
                        cnt       <= HOLD_LOAD;
                        sys_reset <= 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (cnt == '0) begin
                        state     <= WAIT_BOOT;
                        cnt       <= BOOT_LOAD;
                        sys_reset <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_BOOT: begin
                    // Violation outranks a PC match, which outranks the timeout.
                    if (capture) begin
                        state     <= RST_HOLD;
                        cnt       <= HOLD_LOAD;
                        sys_reset <= 1'b1;
                    end else if (pc == RESET_HANDLER) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        boot_fail <= 1'b1;
                        state     <= RST_HOLD;
                        cnt       <= HOLD_LOAD;
                        sys_reset <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sys_reset <= 1'b0;
                end
            endcase
        end
    end

`ifdef UCCA_VIOL_LOG_EN
    ucca_viol_log #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (log_entry_w(NUM_SRC))
    ) u_log (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data ({viol_in, pc, data_addr}),
        .pop       (log_rd),
        .empty     (log_empty),
        .head      (log_data)
    );
`endif

endmodule

// File: tb/tb_ucca_violation_handler.sv
// Directed self-checking bench for ucca_violation_handler (default parameters).
module tb_ucca_violation_handler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  viol_in;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        sys_reset;
    logic        viol_valid;
    logic [3:0]  viol_cause;
    logic [15:0] viol_pc;
    logic [15:0] viol_addr;
    logic [7:0]  viol_count;
    logic        boot_fail;
`ifdef UCCA_VIOL_LOG_EN
    logic        log_rd;
    logic        log_empty;
    logic [35:0] log_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ucca_violation_handler dut (
        .clk        (clk),
        .reset      (reset),
        .viol_in    (viol_in),
        .pc         (pc),
        .data_addr  (data_addr),
        .sys_reset  (sys_reset),
        .viol_valid (viol_valid),
        .viol_cause (viol_cause),
        .viol_pc    (viol_pc),
        .viol_addr  (viol_addr),
        .viol_count (viol_count),
        .boot_fail  (boot_fail)
`ifdef UCCA_VIOL_LOG_EN
        ,
        .log_rd     (log_rd),
        .log_empty  (log_empty),
        .log_data   (log_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fires one violation from IDLE, waits out the hold, then reboots cleanly back to IDLE.
    task automatic do_violation(input logic [3:0] c, input logic [15:0] p, input logic [15:0] a);
        int guard;
        viol_in = c; pc = p; data_addr = a;
        step();
        viol_in = '0; pc = 16'h1234; data_addr = '0;
        guard = 0;
        while (sys_reset === 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            failures++;
            $display("FAIL do_violation_timeout got sys_reset=%b exp=0", sys_reset);
        end
        pc = 16'h0000;
        step();
        pc = 16'h1234;
    endtask

    task automatic test_reset();
        reset = 1'b1; viol_in = '0; pc = 16'h1234; data_addr = '0;
`ifdef UCCA_VIOL_LOG_EN
        log_rd = 1'b0;
`endif
        step(); step();
        reset = 1'b0;
        checks++; if (sys_reset !== 1'b0) begin failures++; $display("FAIL reset_sys_reset got=%b exp=0", sys_reset); end
        checks++; if (viol_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", viol_valid); end
        checks++; if (viol_cause !== 4'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", viol_cause); end
        checks++; if (viol_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", viol_pc); end
        checks++; if (viol_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", viol_addr); end
        checks++; if (viol_count !== 8'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", viol_count); end
        checks++; if (boot_fail !== 1'b0) begin failures++; $display("FAIL reset_boot_fail got=%b exp=0", boot_fail); end
`ifdef UCCA_VIOL_LOG_EN
        checks++; if (log_empty !== 1'b1) begin failures++; $display("FAIL reset_log_empty got=%b exp=1", log_empty); end
`endif
    endtask

    task automatic test_capture();
        int w = 0;
        int guard = 0;
        viol_in = 4'b0010; pc = 16'hE010; data_addr = 16'h0200;
        step();
        viol_in = '0; pc = 16'h1234; data_addr = '0;
        checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL cap_latency got=%b exp=1", sys_reset); end
        checks++; if (viol_cause !== 4'b0010) begin failures++; $display("FAIL cap_cause got=%b exp=0010", viol_cause); end
        checks++; if (viol_pc !== 16'hE010) begin failures++; $display("FAIL cap_pc got=%h exp=e010", viol_pc); end
        checks++; if (viol_addr !== 16'h0200) begin failures++; $display("FAIL cap_addr got=%h exp=0200", viol_addr); end
        checks++; if (viol_count !== 8'd1) begin failures++; $display("FAIL cap_count got=%0d exp=1", viol_count); end
        checks++; if (viol_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", viol_valid); end
        while (sys_reset === 1'b1 && guard < 100) begin
            w++; step(); guard++;
        end
        checks++; if (w != 16) begin failures++; $display("FAIL cap_width got=%0d exp=16", w); end
    endtask

    task automatic test_boot_timeout();
        int low = 0;
        int guard = 0;
        while (sys_reset === 1'b0 && guard < 300) begin
            low++; step(); guard++;
        end
        checks++; if (low != 64) begin failures++; $display("FAIL timeout_len got=%0d exp=64", low); end
        checks++; if (boot_fail !== 1'b1) begin failures++; $display("FAIL timeout_boot_fail got=%b exp=1", boot_fail); end
        checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL timeout_reassert got=%b exp=1", sys_reset); end
        checks++; if (viol_count !== 8'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", viol_count); end
        checks++; if (viol_cause !== 4'b0010) begin failures++; $display("FAIL timeout_cause got=%b exp=0010", viol_cause); end
    endtask

    // Entered at the first sample of the re-issued hold.
    task automatic test_hold_ignore();
        int w = 0;
        int guard = 0;
        viol_in = 4'b0001; pc = 16'hBEEF; data_addr = 16'h0999;
        while (sys_reset === 1'b1 && guard < 100) begin
            w++; step(); guard++;
        end
        viol_in = '0; pc = 16'h1234; data_addr = '0;
        checks++; if (w != 16) begin failures++; $display("FAIL hold_width got=%0d exp=16", w); end
        checks++; if (viol_cause !== 4'b0010) begin failures++; $display("FAIL hold_cause got=%b exp=0010", viol_cause); end
        checks++; if (viol_pc !== 16'hE010) begin failures++; $display("FAIL hold_pc got=%h exp=e010", viol_pc); end
        checks++; if (viol_count !== 8'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", viol_count); end
    endtask

    // Entered at the first WAIT_BOOT sample.
    task automatic test_priority();
        int guard = 0;
        int highs = 0;
        viol_in = 4'b0100; pc = 16'h0000; data_addr = 16'h0300;
        step();
        viol_in = '0; pc = 16'h1234; data_addr = '0;
        checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL prio_reset got=%b exp=1", sys_reset); end
        checks++; if (viol_cause !== 4'b0100) begin failures++; $display("FAIL prio_cause got=%b exp=0100", viol_cause); end
        checks++; if (viol_pc !== 16'h0000) begin failures++; $display("FAIL prio_pc got=%h exp=0000", viol_pc); end
        checks++; if (viol_addr !== 16'h0300) begin failures++; $display("FAIL prio_addr got=%h exp=0300", viol_addr); end
        checks++; if (viol_count !== 8'd2) begin failures++; $display("FAIL prio_count got=%0d exp=2", viol_count); end
        while (sys_reset === 1'b1 && guard < 100) begin
            step(); guard++;
        end
        pc = 16'h0000;
        step();
        pc = 16'h1234;
        repeat (100) begin
            step();
            if (sys_reset === 1'b1) highs++;
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL pc_match_idle got=%0d exp=0", highs); end
        checks++; if (boot_fail !== 1'b1) begin failures++; $display("FAIL boot_fail_sticky got=%b exp=1", boot_fail); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            do_violation(4'b1000, 16'hC000, 16'h0400);
            if (i == 99) begin
                checks++; if (viol_count !== 8'd102) begin failures++; $display("FAIL count_mid got=%0d exp=102", viol_count); end
            end
        end
        checks++; if (viol_count !== 8'd255) begin failures++; $display("FAIL count_sat got=%0d exp=255", viol_count); end
        checks++; if (viol_cause !== 4'b1000) begin failures++; $display("FAIL sat_cause got=%b exp=1000", viol_cause); end
    endtask

    task automatic test_reset_mid();
        viol_in = 4'b0001;
        step();
        viol_in = '0;
        step(); step();
        checks++; if (sys_reset !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", sys_reset); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (sys_reset !== 1'b0) begin failures++; $display("FAIL mid_sys_reset got=%b exp=0", sys_reset); end
        checks++; if (viol_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", viol_valid); end
        checks++; if (viol_cause !== 4'h0) begin failures++; $display("FAIL mid_cause got=%h exp=0", viol_cause); end
        checks++; if (viol_count !== 8'h0) begin failures++; $display("FAIL mid_count got=%0d exp=0", viol_count); end
        checks++; if (boot_fail !== 1'b0) begin failures++; $display("FAIL mid_boot_fail got=%b exp=0", boot_fail); end
        step();
        checks++; if (sys_reset !== 1'b0) begin failures++; $display("FAIL mid_stays_low got=%b exp=0", sys_reset); end
    endtask

`ifdef UCCA_VIOL_LOG_EN
    task automatic test_log();
        logic [35:0] exp_e;
        for (int k = 1; k <= 6; k++) begin
            do_violation(4'(k), 16'(16'hE000 + k), 16'(16'h0200 + k));
        end
        for (int k = 3; k <= 6; k++) begin
            exp_e = {4'(k), 16'(16'hE000 + k), 16'(16'h0200 + k)};
            checks++; if (log_data !== exp_e) begin failures++; $display("FAIL log_entry%0d got=%h exp=%h", k, log_data, exp_e); end
            log_rd = 1'b1;
            step();
            log_rd = 1'b0;
        end
        checks++; if (log_empty !== 1'b1) begin failures++; $display("FAIL log_empty got=%b exp=1", log_empty); end
        log_rd = 1'b1;
        step();
        log_rd = 1'b0;
        checks++; if (log_empty !== 1'b1) begin failures++; $display("FAIL log_empty_pop got=%b exp=1", log_empty); end
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_boot_timeout();
        test_hold_ignore();
        test_priority();
        test_saturation();
        test_reset_mid();
`ifdef UCCA_VIOL_LOG_EN
        test_reset();
        test_log();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
